// File: rtl/irq_controller.sv
// ---------------------------------------------------------------------------
// irq_controller
//   Collects N_IRQ external interrupt lines and synchronises them. Each line
//   has an enable mask and an edge/level mode. Lines are prioritised with the
//   lowest index first, and one request is presented to cop0's external
//   interrupt input. An interrupt is tracked through request, acknowledge and
//   eret, so only one external interrupt is outstanding at a time.
//
// Ports
//   i_clk      single clock, rising edge
//   i_rst      asynchronous reset, active-high
//   i_irq      raw interrupt lines (asynchronous to i_clk)
//   i_we       register write strobe (mtc0)
//   i_address  register address
//   i_data     register write data
//   o_data     register read data, combinational from i_address (unmapped -> 0)
//   i_ack      cop0 took the external exception
//   i_eret     eret executed (handler done)
//   o_irq      registered request to cop0
//   o_irq_id   id of the line currently requested / in service
//
// Registers
//   MASK_ADDR  MASK    RW   bit=1 enables the line
//   PEND_ADDR  PENDING R    write-1-to-clear
//   MODE_ADDR  MODE    RW   bit=1 edge, bit=0 level
//   ID_ADDR    ID      R    {in_service, zero pad, o_irq_id}
// ---------------------------------------------------------------------------
module irq_controller #(
    parameter int         N_IRQ     = 8,
    parameter int         ID_W      = (N_IRQ > 1) ? $clog2(N_IRQ) : 1,
    parameter logic [4:0] MASK_ADDR = 5'd16,
    parameter logic [4:0] PEND_ADDR = 5'd17,
    parameter logic [4:0] MODE_ADDR = 5'd18,
    parameter logic [4:0] ID_ADDR   = 5'd19
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_IRQ-1:0] i_irq,
    input  logic             i_we,
    input  logic [4:0]       i_address,
    input  logic [31:0]      i_data,
    output logic [31:0]      o_data,
    input  logic             i_ack,
    input  logic             i_eret,
    output logic             o_irq,
    output logic [ID_W-1:0]  o_irq_id
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        REQUEST    = 2'd1,
        IN_SERVICE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N_IRQ-1:0]  s1_q, s1_d;
    logic [N_IRQ-1:0]  s2_q, s2_d;
    logic [N_IRQ-1:0]  s3_q, s3_d;
    logic [N_IRQ-1:0]  mask_q, mask_d;
    logic [N_IRQ-1:0]  mode_q, mode_d;
    logic [N_IRQ-1:0]  pend_q, pend_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              irq_q, irq_d;

    logic [N_IRQ-1:0]  pend_set;
    logic [N_IRQ-1:0]  pend_clr;
    logic [N_IRQ-1:0]  active;
    logic [ID_W-1:0]   best_id;
    logic              wr_mask, wr_mode, wr_pend;

    // ------------------------------------------------------------------
    // Datapath: synchroniser, register writes, pending set/clear
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can
        // leave a signal unassigned and infer a latch.
        s1_d   = i_irq;
        s2_d   = s1_q;
        s3_d   = s2_q;
        mask_d = mask_q;
        mode_d = mode_q;

        wr_mask = i_we && (i_address == MASK_ADDR);
        wr_mode = i_we && (i_address == MODE_ADDR);
        wr_pend = i_we && (i_address == PEND_ADDR);

        // Only the low N_IRQ bits are stored, so upper bits ignore writes.
        if (wr_mask) mask_d = i_data[N_IRQ-1:0];
        if (wr_mode) mode_d = i_data[N_IRQ-1:0];

        // Edge lines set on a synchronised rising edge; level lines set
        // whenever they are high.
        pend_set = (s2_q & ~s3_q & mode_q) | (s2_q & ~mode_q);

        pend_clr = '0;
        if (wr_pend) pend_clr = i_data[N_IRQ-1:0];
        // The acknowledge consumes an edge interrupt. A level line stays
        // pending until software clears it at the source and then by W1C.
        if (i_ack && (state_q == REQUEST) && mode_q[id_q])
            pend_clr = pend_clr | (N_IRQ'(1) << id_q);

        // Set wins over clear, so a level line that is still high stays pending.
        pend_d = (pend_q & ~pend_clr) | pend_set;
    end

    assign active = pend_q & mask_q;

    // Lowest index wins: scan downwards so the last hit is the lowest.
    always_comb begin
        best_id = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (active[i]) best_id = ID_W'(i);
        end
    end

    // ------------------------------------------------------------------
    // Request / service FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        unique case (state_q)
            IDLE: begin
                if (|active) begin
                    state_d = REQUEST;
                    id_d    = best_id;
                end
            end
            REQUEST: begin
                // The id is frozen while requesting. Ack beats a same-cycle
                // withdrawal.
                if (i_ack)
                    state_d = IN_SERVICE;
                else if (!active[id_q])
                    state_d = IDLE;
            end
            IN_SERVICE: begin
                if (i_eret) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        irq_d = (state_d == REQUEST);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples pre-edge values regardless of statement order.
        if (i_rst) begin
            state_q <= IDLE;
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            mask_q  <= '0;
            mode_q  <= '0;
            pend_q  <= '0;
            id_q    <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            pend_q  <= pend_d;
            id_q    <= id_d;
            irq_q   <= irq_d;
        end
    end

    assign o_irq    = irq_q;
    assign o_irq_id = id_q;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        o_data = 32'd0;
        if (i_address == MASK_ADDR)
            o_data = 32'(mask_q);
        else if (i_address == PEND_ADDR)
            o_data = 32'(pend_q);
        else if (i_address == MODE_ADDR)
            o_data = 32'(mode_q);
        else if (i_address == ID_ADDR)
            o_data = {(state_q == IN_SERVICE), {(31 - ID_W){1'b0}}, id_q};
    end

    // Write-data bits above the line count have no storage.
    if (N_IRQ < 32) begin : g_unused_data
        logic unused_data;
        assign unused_data = ^i_data[31:N_IRQ];
    end

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;

    localparam logic [4:0] A_MASK = 5'd16;
    localparam logic [4:0] A_PEND = 5'd17;
    localparam logic [4:0] A_MODE = 5'd18;
    localparam logic [4:0] A_ID   = 5'd19;

    logic        i_clk;
    logic        i_rst;
    logic [7:0]  i_irq;
    logic        i_we;
    logic [4:0]  i_address;
    logic [31:0] i_data;
    logic [31:0] o_data;
    logic        i_ack;
    logic        i_eret;
    logic        o_irq;
    logic [2:0]  o_irq_id;

    int checks = 0;
    int errors = 0;
    logic [31:0] rdata;

    irq_controller dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_irq     (i_irq),
        .i_we      (i_we),
        .i_address (i_address),
        .i_data    (i_data),
        .o_data    (o_data),
        .i_ack     (i_ack),
        .i_eret    (i_eret),
        .o_irq     (o_irq),
        .o_irq_id  (o_irq_id)
    );

    initial i_clk = 1'b0;
    always #10 i_clk = ~i_clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        i_address = a;
        #1;
        d = o_data;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        i_we      = 1'b1;
        i_address = a;
        i_data    = d;
        step();
        i_we      = 1'b0;
        i_data    = 32'd0;
    endtask

    task automatic pulse_ack();
        i_ack = 1'b1;
        step();
        i_ack = 1'b0;
    endtask

    task automatic pulse_eret();
        i_eret = 1'b1;
        step();
        i_eret = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        step(2);
        checks++; if (o_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", o_irq); end
        checks++; if (o_irq_id !== 3'd0) begin errors++; $display("FAIL reset_id got %0d exp 0", o_irq_id); end
        rd(A_MASK, rdata);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_mask got %h exp 0", rdata); end
        rd(A_PEND, rdata);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_pend got %h exp 0", rdata); end
        rd(A_ID, rdata);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_idreg got %h exp 0", rdata); end
        i_rst = 1'b0;
        step();
    endtask

    task automatic test_registers();
        wr(A_MASK, 32'hFFFF_FFFF);
        rd(A_MASK, rdata);
        checks++; if (rdata !== 32'h0000_00FF) begin errors++; $display("FAIL mask_width got %h exp 000000ff", rdata); end
        wr(A_MODE, 32'hFFFF_FF5A);
        rd(A_MODE, rdata);
        checks++; if (rdata !== 32'h0000_005A) begin errors++; $display("FAIL mode_rw got %h exp 0000005a", rdata); end
        rd(5'd0, rdata);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL unmapped got %h exp 0", rdata); end
        wr(A_MASK, 32'h0);
        wr(A_MODE, 32'h0);
        checks++; if (o_irq !== 1'b0) begin errors++; $display("FAIL regs_no_irq got %b exp 0", o_irq); end
    endtask

    task automatic test_level_basic();
        wr(A_MASK, 32'h01);
        i_irq[0] = 1'b1;
        step(3);
        checks++; if (o_irq !== 1'b0) begin errors++; $display("FAIL lat_edge3 got %b exp 0", o_irq); end
        step();
        checks++; if (o_irq !== 1'b1) begin errors++; $display("FAIL lat_edge4 got %b exp 1", o_irq); end
        checks++; if (o_irq_id !== 3'd0) begin errors++; $display("FAIL t1_id got %0d exp 0", o_irq_id); end
        pulse_ack();
        checks++; if (o_irq !== 1'b0) begin errors++; $display("FAIL t1_ack_irq got %b exp 0", o_irq); end
        rd(A_ID, rdata);
        checks++; if (rdata !== 32'h8000_0000) begin errors++; $display("FAIL t1_inserv got %h exp 80000000", rdata); end
        // Level ack leaves the line pending; clean up at the source then W1C.
        i_irq[0] = 1'b0;
        step(3);
        wr(A_PEND, 32'h01);
        pulse_eret();
        step();
        checks++; if (o_irq !== 1'b0) begin errors++; $display("FAIL t1_idle got %b exp 0", o_irq); end
        rd(A_ID, rdata);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL t1_idreg got %h exp 0", rdata); end
    endtask

    task automatic test_priority();
        wr(A_MASK, 32'hFF);
        i_irq[3] = 1'b1;
        i_irq[5] = 1'b1;
        step(4);
        checks++; if (o_irq !== 1'b1) begin errors++; $display("FAIL t2_irq got %b exp 1", o_irq); end
        checks++; if (o_irq_id !== 3'd3) begin errors++; $display("FAIL t2_id got %0d exp 3", o_irq_id); end
        rd(A_PEND, rdata);
        checks++; if (rdata !== 32'h28) begin errors++; $display("FAIL t2_pend got %h exp 28", rdata); end
        pulse_ack();
        rd(A_ID, rdata);
        checks++; if (rdata !== 32'h8000_0003) begin errors++; $display("FAIL t2_inserv got %h exp 80000003", rdata); end
        i_irq[3] = 1'b0;
        step(3);
        wr(A_PEND, 32'h08);
        pulse_eret();
        checks++; if (o_irq !== 1'b0) begin errors++; $display("FAIL t2_gap got %b exp 0", o_irq); end
        step();
        checks++; if (o_irq !== 1'b1) begin errors++; $display("FAIL t2_next_irq got %b exp 1", o_irq); end
        checks++; if (o_irq_id !== 3'd5) begin errors++; $display("FAIL t2_next_id got %0d exp 5", o_irq_id); end
        pulse_ack();
        i_irq[5] = 1'b0;
        step(3);
        wr(A_PEND, 32'h20);
        pulse_eret();
        step();
        checks++; if (o_irq !== 1'b0) begin errors++; $display("FAIL t2_done got %b exp 0", o_irq); end
        rd(A_PEND, rdata);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL t2_pend_clr got %h exp 0", rdata); end
    endtask

    task automatic test_edge_withdraw();
        wr(A_MODE, 32'h04);
        wr(A_MASK, 32'h04);
        i_irq[2] = 1'b1;
        step(2);
        i_irq[2] = 1'b0;
        step(2);
        checks++; if (o_irq !== 1'b1) begin errors++; $display("FAIL t3_irq got %b exp 1", o_irq); end
        rd(A_PEND, rdata);
        checks++; if (rdata !== 32'h04) begin errors++; $display("FAIL t3_pend got %h exp 04", rdata); end
        wr(A_PEND, 32'h04);
        rd(A_PEND, rdata);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL t3_w1c got %h exp 0", rdata); end
        step();
        checks++; if (o_irq !== 1'b0) begin errors++; $display("FAIL t3_withdraw got %b exp 0", o_irq); end
        rd(A_ID, rdata);
        checks++; if (rdata !== 32'h02) begin errors++; $display("FAIL t3_idreg got %h exp 02", rdata); end
        step(2);
        checks++; if (o_irq !== 1'b0) begin errors++; $display("FAIL t3_no_reraise got %b exp 0", o_irq); end
    endtask

    task automatic test_level_w1c();
        wr(A_MODE, 32'h0);
        i_irq[1] = 1'b1;
        step(3);
        rd(A_PEND, rdata);
        checks++; if (rdata !== 32'h02) begin errors++; $display("FAIL t4_pend got %h exp 02", rdata); end
        wr(A_PEND, 32'h02);
        rd(A_PEND, rdata);
        checks++; if (rdata !== 32'h02) begin errors++; $display("FAIL t4_set_wins got %h exp 02", rdata); end
        i_irq[1] = 1'b0;
        step(3);
        wr(A_PEND, 32'h02);
        rd(A_PEND, rdata);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL t4_cleared got %h exp 0", rdata); end
        checks++; if (o_irq !== 1'b0) begin errors++; $display("FAIL t4_masked got %b exp 0", o_irq); end
    endtask

    task automatic test_async_reset();
        wr(A_MASK, 32'h01);
        wr(A_MODE, 32'h80);
        i_irq[0] = 1'b1;
        step(4);
        pulse_ack();
        rd(A_ID, rdata);
        checks++; if (rdata !== 32'h8000_0000) begin errors++; $display("FAIL t5_inserv got %h exp 80000000", rdata); end
        rd(A_PEND, rdata);
        checks++; if (rdata !== 32'h01) begin errors++; $display("FAIL t5_pend_pre got %h exp 01", rdata); end
        @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        checks++; if (o_irq !== 1'b0) begin errors++; $display("FAIL t5_irq got %b exp 0", o_irq); end
        checks++; if (o_irq_id !== 3'd0) begin errors++; $display("FAIL t5_id got %0d exp 0", o_irq_id); end
        rd(A_MASK, rdata);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL t5_mask got %h exp 0", rdata); end
        rd(A_PEND, rdata);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL t5_pend got %h exp 0", rdata); end
        rd(A_MODE, rdata);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL t5_mode got %h exp 0", rdata); end
        rd(A_ID, rdata);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL t5_idreg got %h exp 0", rdata); end
        i_irq = 8'h00;
        step(2);
        i_rst = 1'b0;
        step();
    endtask

    task automatic test_ack_w1c_same_cycle();
        wr(A_MASK, 32'h01);
        wr(A_MODE, 32'h01);
        i_irq[0] = 1'b1;
        step(4);
        checks++; if (o_irq !== 1'b1) begin errors++; $display("FAIL t6_irq got %b exp 1", o_irq); end
        i_ack     = 1'b1;
        i_we      = 1'b1;
        i_address = A_PEND;
        i_data    = 32'h01;
        step();
        i_ack  = 1'b0;
        i_we   = 1'b0;
        i_data = 32'h0;
        rd(A_ID, rdata);
        checks++; if (rdata !== 32'h8000_0000) begin errors++; $display("FAIL t6_inserv got %h exp 80000000", rdata); end
        rd(A_PEND, rdata);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL t6_pend got %h exp 0", rdata); end
        pulse_eret();
        step();
        checks++; if (o_irq !== 1'b0) begin errors++; $display("FAIL t6_idle got %b exp 0", o_irq); end
        // Second edge: the acknowledge alone consumes the pending bit.
        i_irq[0] = 1'b0;
        step(3);
        i_irq[0] = 1'b1;
        step(4);
        rd(A_PEND, rdata);
        checks++; if (rdata !== 32'h01) begin errors++; $display("FAIL t6_pend2 got %h exp 01", rdata); end
        pulse_ack();
        rd(A_PEND, rdata);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL t6_ack_clr got %h exp 0", rdata); end
        pulse_eret();
        step();
        checks++; if (o_irq !== 1'b0) begin errors++; $display("FAIL t6_end got %b exp 0", o_irq); end
        i_irq[0] = 1'b0;
    endtask

    initial begin
        i_rst     = 1'b1;
        i_irq     = 8'h00;
        i_we      = 1'b0;
        i_address = 5'd0;
        i_data    = 32'd0;
        i_ack     = 1'b0;
        i_eret    = 1'b0;
        test_reset();
        test_registers();
        test_level_basic();
        test_priority();
        test_edge_withdraw();
        test_level_w1c();
        test_async_reset();
        test_ack_w1c_same_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
